kbd_event_sequencer: RTL and testbench
======================================

// Module: kbd_event_sequencer
// PURPOSE
//  Sits between ps2_intf and the 8x8 LM80C keyboard matrix read by the VTL/PIO scan port.
//  Decodes PS/2 bytes into key events (E0/F0 prefixes) and queues them in a FIFO.
//  Applies events to the matrix one at a time, holding each change >= HOLD_CYCLES.
//  This guarantees that fast press/release pairs are seen by the slow CPU scan.
// PARAMETERS
//  FIFO_DEPTH   8      event FIFO entries; power of 2, >= 2
//  HOLD_CYCLES  50000  minimum clk cycles between successive matrix changes; >= 1
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  kdata      in   8  byte from ps2_intf
//  kvalid     in   1  kdata valid; one-cycle pulse per byte
//  flush      in   1  synchronous: empty FIFO and release all keys
//  port_A     in   8  row select, active low; several rows may be low
//  port_B     out  8  column data, active low; 1 = no key
//  reset_key  out  1  high while F12 is held
//  overflow   out  1  sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values (reset_n low, async): matrix KM[0..7] = 8'hFF; FIFO empty.
//   ext/rel flags = 0; state IDLE; hold counter = 0; reset_key = 0; overflow = 0.
//  Prefix decode, on each kvalid:
//   E0 sets ext. F0 sets rel. Any other byte completes the event {rel,ext,code}.
//   Completing an event clears both flags in the same cycle.
//  Key map: combinational function keymap({ext,code}) -> {hit,row[2:0],col[2:0]}.
//   Table defined at the end of this file. Fixed entries:
//   1C(A) -> r1c2; 21(C) -> r2c4; 16(1) -> r0c0.
//   Extended codes map only where listed; E0 21 is unmapped. Unmapped events are discarded.
//  F12 (non-ext 07): reset_key <= !rel on completion. Not queued; the matrix is untouched.
//  Push: a mapped event writes {rel,row,col} (7 bits) the cycle after the final byte.
//   Full FIFO: the event is dropped and overflow <= 1 until reset.
//   Push onto a full FIFO is accepted if a pop occurs in the same cycle.
//   Typematic filter: a press whose matrix bit is already 0 is discarded when the FIFO is empty.
//  Apply FSM:
//   IDLE: FIFO not empty -> pop; KM[row][col] <= rel (0 = pressed); counter <= HOLD_CYCLES-1; -> HOLD.
//   HOLD: counter decrements each cycle; at 0 -> IDLE.
//   IDLE pops again no earlier than the following cycle.
//  Latency: final byte kvalid at cycle t -> FIFO entry at t+1 -> matrix bit change visible at t+2.
//   This holds when the FSM is in IDLE with the FIFO empty.
//  Spacing: consecutive matrix changes are >= HOLD_CYCLES+1 cycles apart.
//  port_B (combinational): AND over rows r of (port_A[r]==0 ? KM[r] : 8'hFF).
//   All rows deselected -> 8'hFF.
//  flush: clears FIFO, sets KM = all 8'hFF, FSM -> IDLE, counter = 0.
//   Flush has priority over push and pop in the same cycle.
//   overflow and reset_key are not cleared by flush.
//  reset_n asserted mid-HOLD or mid-prefix: all state returns to reset values immediately.
//   A partial prefix sequence is lost.
// TESTING (HOLD_CYCLES=4 unless noted)
//  1. Bytes 1C -> at t+2 port_A=FD gives port_B=FB; port_A=FE gives FF.
//  2. Bytes 21,F0,21 back to back -> port_A=FB: port_B bit4 = 0 for exactly 5 cycles, then 1.
//  3. FIFO_DEPTH=4, HOLD=1000, six distinct presses -> 1 applied, 4 queued, 6th dropped, overflow=1.
//  4. E0,21 then 21 -> the first event is ignored with no matrix change; the second presses C (r2c4).
//  5. 07 -> reset_key=1; F0,07 -> reset_key=0; port_B stays FF with port_A=00.
//  6. Press A, then reset_n low during HOLD -> port_B=FF, overflow=0, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/kbd_event_sequencer_if.sv
// PS/2 byte stream from ps2_intf into the keyboard event sequencer.
interface kbd_event_sequencer_if;
    logic [7:0] kdata;
    logic       kvalid;

    modport master (output kdata, output kvalid);
    modport slave  (input  kdata, input  kvalid);
endinterface

// File: rtl/kbd_event_sequencer.sv
// Decodes PS/2 scan bytes into key events, queues them, and applies them one at
// a time to the LM80C 8x8 keyboard matrix with a minimum hold between changes.
module kbd_event_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    kbd_event_sequencer_if.slave  kbd,
    input  logic                  flush,
    input  logic [7:0]            port_A,
    output logic [7:0]            port_B,
    output logic                  reset_key,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    // {ext,code} -> {hit,row,col}; anything not listed is unmapped
    function automatic logic [6:0] keymap(input logic ext, input logic [7:0] code);
        logic [6:0] m;
        case ({ext, code})
            9'h016: m = {1'b1, 3'd0, 3'd0};  9'h01E: m = {1'b1, 3'd0, 3'd1};
            9'h026: m = {1'b1, 3'd0, 3'd2};  9'h025: m = {1'b1, 3'd0, 3'd3};
            9'h02E: m = {1'b1, 3'd0, 3'd4};  9'h036: m = {1'b1, 3'd0, 3'd5};
            9'h03D: m = {1'b1, 3'd0, 3'd6};  9'h03E: m = {1'b1, 3'd0, 3'd7};
            9'h015: m = {1'b1, 3'd1, 3'd0};  9'h01D: m = {1'b1, 3'd1, 3'd1};
            9'h01C: m = {1'b1, 3'd1, 3'd2};  9'h01B: m = {1'b1, 3'd1, 3'd3};
            9'h024: m = {1'b1, 3'd1, 3'd4};  9'h02D: m = {1'b1, 3'd1, 3'd5};
            9'h02C: m = {1'b1, 3'd1, 3'd6};  9'h035: m = {1'b1, 3'd1, 3'd7};
            9'h01A: m = {1'b1, 3'd2, 3'd0};  9'h022: m = {1'b1, 3'd2, 3'd1};
            9'h023: m = {1'b1, 3'd2, 3'd2};  9'h02B: m = {1'b1, 3'd2, 3'd3};
            9'h021: m = {1'b1, 3'd2, 3'd4};  9'h02A: m = {1'b1, 3'd2, 3'd5};
            9'h034: m = {1'b1, 3'd2, 3'd6};  9'h032: m = {1'b1, 3'd2, 3'd7};
            9'h029: m = {1'b1, 3'd3, 3'd0};  9'h05A: m = {1'b1, 3'd3, 3'd1};
            9'h066: m = {1'b1, 3'd3, 3'd2};  9'h076: m = {1'b1, 3'd3, 3'd3};
            9'h012: m = {1'b1, 3'd3, 3'd4};  9'h059: m = {1'b1, 3'd3, 3'd5};
            9'h014: m = {1'b1, 3'd3, 3'd6};  9'h011: m = {1'b1, 3'd3, 3'd7};
            9'h114: m = {1'b1, 3'd3, 3'd6};  9'h111: m = {1'b1, 3'd3, 3'd7};
            9'h175: m = {1'b1, 3'd4, 3'd0};  9'h172: m = {1'b1, 3'd4, 3'd1};
            9'h16B: m = {1'b1, 3'd4, 3'd2};  9'h174: m = {1'b1, 3'd4, 3'd3};
            default: m = 7'h00;
        endcase
        return m;
    endfunction

    logic            ext_r, rel_r;
    logic [7:0][7:0] km_r;
    logic [6:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r;
    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            reset_key_r, overflow_r;

    logic       is_e0_s, is_f0_s, complete_s, f12_s;
    logic [6:0] map_s, pop_word_s;
    logic [2:0] row_s, col_s;
    logic       fifo_empty_s, fifo_full_s, typematic_s;
    logic       pop_s, push_req_s, push_s, drop_s;
    logic [7:0] port_b_s;

    assign is_e0_s      = kbd.kvalid && (kbd.kdata == 8'hE0);
    assign is_f0_s      = kbd.kvalid && (kbd.kdata == 8'hF0);
    assign complete_s   = kbd.kvalid && !is_e0_s && !is_f0_s;
    assign f12_s        = complete_s && !ext_r && (kbd.kdata == 8'h07);
    assign map_s        = keymap(ext_r, kbd.kdata);
    assign row_s        = map_s[5:3];
    assign col_s        = map_s[2:0];
    assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
    assign fifo_full_s  = (count_r == FIFO_FULL);
    // A repeated press of a key already held in the matrix carries no information
    assign typematic_s  = !rel_r && !km_r[row_s][col_s] && fifo_empty_s;
    assign pop_s        = (state_r == IDLE) && !fifo_empty_s && !flush;
    assign push_req_s   = complete_s && map_s[6] && !typematic_s && !flush;
    assign push_s       = push_req_s && (!fifo_full_s || pop_s);
    assign drop_s       = push_req_s && fifo_full_s && !pop_s;
    assign pop_word_s   = mem_r[rd_ptr_r];

    // Prefix flags, F12 reset key and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_r       <= 1'b0;
            rel_r       <= 1'b0;
            reset_key_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (complete_s) begin
                ext_r <= 1'b0;
                rel_r <= 1'b0;
            end else if (is_e0_s) begin
                ext_r <= 1'b1;
            end else if (is_f0_s) begin
                rel_r <= 1'b1;
            end
            if (f12_s) reset_key_r <= !rel_r;
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    // Event FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= {rel_r, row_s, col_s};
    end

    // Event FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Keyboard matrix, one bit changed per popped event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            km_r <= {8{8'hFF}};
        end else if (flush) begin
            km_r <= {8{8'hFF}};
        end else if (pop_s) begin
            km_r[pop_word_s[5:3]][pop_word_s[2:0]] <= pop_word_s[6];
        end
    end

    // Apply FSM state and hold counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Apply FSM next state: pop in IDLE, then wait out the hold time
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (flush) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_s = HOLD;
                        cnt_s   = HOLD_LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                HOLD: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Column read-back: AND of every selected row
    always_comb begin
        port_b_s = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!port_A[r]) begin
                port_b_s = port_b_s & km_r[r];
            end else begin
                port_b_s = port_b_s;
            end
        end
    end

    assign port_B    = port_b_s;
    assign reset_key = reset_key_r;
    assign overflow  = overflow_r;
endmodule

// File: tb/tb_kbd_event_sequencer.sv
// Scoreboard bench: stimulus queues expected port_B changes with their cycle,
// per-DUT monitors pop and compare whenever port_B changes.
module tb_kbd_event_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, reset_n_b, flush, flush_b;
    logic [7:0] port_A, port_A_b, port_B, port_B_b;
    logic       reset_key, reset_key_b, overflow, overflow_b;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         exp_val_a[$], exp_cyc_a[$], exp_val_b[$], exp_cyc_b[$];
    bit         mon_a = 1'b0, mon_b = 1'b0;
    logic [7:0] last_a, last_b;
    int         c;

    kbd_event_sequencer_if ifa ();
    kbd_event_sequencer_if ifb ();

    kbd_event_sequencer #(.FIFO_DEPTH(8), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .kbd(ifa), .flush(flush), .port_A(port_A),
        .port_B(port_B), .reset_key(reset_key), .overflow(overflow));

    kbd_event_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(1000)) dut_b (
        .clk(clk), .reset_n(reset_n_b), .kbd(ifb), .flush(flush_b), .port_A(port_A_b),
        .port_B(port_B_b), .reset_key(reset_key_b), .overflow(overflow_b));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor_a
        int v, t;
        if (mon_a && (port_B !== last_a)) begin
            if (exp_val_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change_a actual=%0h required=%0h (cycle %0d)", port_B, last_a, cyc);
            end else begin
                v = exp_val_a.pop_front();
                t = exp_cyc_a.pop_front();
                check("portB_a", int'(port_B), v);
                check("cycle_a", cyc, t);
            end
        end
        last_a = port_B;
    end

    always @(negedge clk) begin : monitor_b
        int v, t;
        if (mon_b && (port_B_b !== last_b)) begin
            if (exp_val_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change_b actual=%0h required=%0h (cycle %0d)", port_B_b, last_b, cyc);
            end else begin
                v = exp_val_b.pop_front();
                t = exp_cyc_b.pop_front();
                check("portB_b", int'(port_B_b), v);
                check("cycle_b", cyc, t);
            end
        end
        last_b = port_B_b;
    end

    task automatic expect_a(input int v, input int t);
        exp_val_a.push_back(v);
        exp_cyc_a.push_back(t);
    endtask

    task automatic expect_b(input int v, input int t);
        exp_val_b.push_back(v);
        exp_cyc_b.push_back(t);
    endtask

    // Called #1 after a rising edge; leaves kvalid low #1 after the next edge
    task automatic send_a(input logic [7:0] b);
        ifa.kdata  = b;
        ifa.kvalid = 1'b1;
        @(posedge clk); #1;
        ifa.kvalid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        ifb.kdata  = b;
        ifb.kvalid = 1'b1;
        @(posedge clk); #1;
        ifb.kvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; reset_n_b = 1'b0; flush = 1'b0; flush_b = 1'b0;
        port_A = 8'h00; port_A_b = 8'h00;
        ifa.kdata = 8'h00; ifa.kvalid = 1'b0; ifb.kdata = 8'h00; ifb.kvalid = 1'b0;
        idle(2);
        reset_n = 1'b1; reset_n_b = 1'b1;
        idle(2);
        check("reset_portB_a", int'(port_B), 8'hFF);
        check("reset_portB_b", int'(port_B_b), 8'hFF);
        check("reset_overflow", int'(overflow), 0);
        check("reset_reset_key", int'(reset_key), 0);

        // Press A: r1c2, visible two cycles after the byte
        port_A = 8'hFD;
        idle(1);
        mon_a = 1'b1;
        c = cyc; expect_a(8'hFB, c + 2);
        send_a(8'h1C);
        idle(10);
        mon_a = 1'b0;
        port_A = 8'hFE; #1 check("rowsel_other", int'(port_B), 8'hFF);
        port_A = 8'hFD; #1 check("rowsel_row1", int'(port_B), 8'hFB);
        port_A = 8'h00; #1 check("rowsel_all", int'(port_B), 8'hFB);
        port_A = 8'hFD;
        idle(1);
        mon_a = 1'b1;
        c = cyc; expect_a(8'hFF, c + 3);
        send_a(8'hF0); send_a(8'h1C);
        idle(10);

        // Fast press/release of C: held low for exactly HOLD+1 cycles
        port_A = 8'hFB;
        idle(1);
        c = cyc; expect_a(8'hEF, c + 2); expect_a(8'hFF, c + 7);
        send_a(8'h21); send_a(8'hF0); send_a(8'h21);
        idle(10);

        // E0 21 is unmapped; the plain 21 that follows presses C
        c = cyc; expect_a(8'hEF, c + 4);
        send_a(8'hE0); send_a(8'h21); send_a(8'h21);
        idle(10);
        // Repeat press while held is filtered, so the release is not delayed
        c = cyc; expect_a(8'hFF, c + 4);
        send_a(8'h21); send_a(8'hF0); send_a(8'h21);
        idle(10);

        // Extended cursor-up on r4c0
        port_A = 8'hEF;
        idle(1);
        c = cyc; expect_a(8'hFE, c + 3);
        send_a(8'hE0); send_a(8'h75);
        idle(10);
        c = cyc; expect_a(8'hFF, c + 4);
        send_a(8'hE0); send_a(8'hF0); send_a(8'h75);
        idle(10);

        // F12 drives reset_key only
        port_A = 8'h00;
        idle(1);
        send_a(8'h07);
        check("f12_press", int'(reset_key), 1);
        idle(3);
        check("f12_matrix", int'(port_B), 8'hFF);

        // Flush mid-hold with an event still queued; reset_key survives
        port_A = 8'hF9;
        idle(1);
        c = cyc; expect_a(8'hFB, c + 2); expect_a(8'hFF, c + 3);
        send_a(8'h1C); send_a(8'h21);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(10);
        check("flush_reset_key", int'(reset_key), 1);
        check("flush_overflow", int'(overflow), 0);
        c = cyc; expect_a(8'hFB, c + 2);
        send_a(8'h1C);
        idle(10);
        c = cyc; expect_a(8'hFF, c + 3);
        send_a(8'hF0); send_a(8'h1C);
        idle(10);
        send_a(8'hF0); send_a(8'h07);
        check("f12_release", int'(reset_key), 0);
        send_a(8'h07);
        check("f12_again", int'(reset_key), 1);

        // Overflow on the 4-deep, 1000-cycle-hold instance
        port_A_b = 8'hFE;
        idle(1);
        mon_b = 1'b1;
        c = cyc;
        expect_b(8'hFE, c + 2);    expect_b(8'hFC, c + 1003);
        expect_b(8'hF8, c + 2004); expect_b(8'hF0, c + 3005);
        expect_b(8'hE0, c + 4006);
        send_b(8'h16); send_b(8'h1E); send_b(8'h26);
        send_b(8'h25); send_b(8'h2E); send_b(8'h36);
        idle(1);
        check("overflow_b_set", int'(overflow_b), 1);
        check("overflow_a_clear", int'(overflow), 0);
        idle(4100);
        check("drain_b_final", int'(port_B_b), 8'hE0);
        check("overflow_b_sticky", int'(overflow_b), 1);

        // Async reset during HOLD with a second event queued
        port_A = 8'hF9;
        idle(1);
        c = cyc; expect_a(8'hFB, c + 2); expect_a(8'hFF, c + 3);
        send_a(8'h1C); send_a(8'h21);
        idle(1);
        reset_n = 1'b0;
        #1;
        check("rst_portB", int'(port_B), 8'hFF);
        check("rst_overflow", int'(overflow), 0);
        check("rst_reset_key", int'(reset_key), 0);
        idle(2);
        reset_n = 1'b1;
        idle(20);
        c = cyc; expect_a(8'hEF, c + 2);
        send_a(8'h21);
        idle(10);

        check("sb_a_drained", exp_val_a.size(), 0);
        check("sb_b_drained", exp_val_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
